// File: rtl/codificador_8a3_secuencial_if.sv
// ---------------------------------------------------------------------------
// codificador_8a3_secuencial_if
//   Bus bundle for the registered 8-to-3 priority encoder.
//   Signals:
//     req_in     [7:0]  request lines; each set bit marks that line pending
//     clear             synchronous flush of pending requests and the output
//     ready             consumer can take code_out this cycle
//     code_out   [2:0]  encoded index of the presented request
//     valid             code_out holds a pending request
//     pending    [7:0]  registered pending-request mask
//     pend_count [3:0]  popcount of pending (0..8)
//     dup_err           sticky: a request hit a line that was already pending
//     state_dbg         encoder FSM state (0 = IDLE, 1 = PRESENT)
//
//   Handshake: a code is transferred at a rising clock edge where
//   valid && ready. While valid is high and ready is low, code_out is held
//   stable and valid stays high. valid never depends on ready
//   combinationally.
// ---------------------------------------------------------------------------
interface codificador_8a3_secuencial_if;
  logic [7:0] req_in;
  logic       clear;
  logic       ready;
  logic [2:0] code_out;
  logic       valid;
  logic [7:0] pending;
  logic [3:0] pend_count;
  logic       dup_err;
  logic       state_dbg;

  // The block that produces requests and consumes codes.
  modport master (
    output req_in, clear, ready,
    input  code_out, valid, pending, pend_count, dup_err, state_dbg
  );

  // The encoder itself.
  modport slave (
    input  req_in, clear, ready,
    output code_out, valid, pending, pend_count, dup_err, state_dbg
  );
endinterface

// File: rtl/codificador_8a3_secuencial.sv
// ---------------------------------------------------------------------------
// codificador_8a3_secuencial
//   Registered 8-to-3 priority encoder with request latching. Request pulses
//   are accumulated into a pending mask; one 3-bit code per pending line is
//   presented on a valid/ready output, highest priority first, and the line
//   is retired when its code is accepted.
//
//   Parameters:
//     PRIORITY_HIGH  1: bit 7 has the highest priority; 0: bit 0 does.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous reset, active low
//     bus    slave modport of codificador_8a3_secuencial_if
//            (req_in, clear, ready in; code_out, valid, pending,
//             pend_count, dup_err, state_dbg out)
// ---------------------------------------------------------------------------
module codificador_8a3_secuencial #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  codificador_8a3_secuencial_if.slave    bus
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_code;
  logic [2:0] w_code_nxt;
  logic [7:0] r_pending;
  logic [7:0] w_pending_nxt;
  logic       r_dup_err;
  logic       w_dup_err_nxt;
  logic       w_ack;
  logic [7:0] w_ack_mask;
  logic [7:0] w_rem;
  logic [3:0] w_count;

  // Index of the highest-priority set bit of a mask (0 when the mask is 0;
  // callers only use the result for a non-zero mask).
  function automatic logic [2:0] f_pick(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (mask[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // A code is retired in the cycle it is accepted; rem is what is left of
  // the registered mask once that line is removed.
  assign w_ack      = (r_state == S_PRESENT) && bus.ready;
  assign w_ack_mask = w_ack ? (8'd1 << r_code) : 8'd0;
  assign w_rem      = r_pending & ~w_ack_mask;

  // A request landing on the line being acknowledged re-arms it without
  // counting as a duplicate, because the old instance has just left.
  always_comb begin
    w_pending_nxt = w_rem | bus.req_in;
    w_dup_err_nxt = r_dup_err | (|(bus.req_in & w_rem));
    if (bus.clear) begin
      w_pending_nxt = 8'd0;
      w_dup_err_nxt = 1'b0;
    end
  end

  // Next state / code. No preemption: while presenting, code_out only moves
  // on a handshake. New requests from the handshake cycle are not in rem,
  // so they are considered one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pending != 8'd0) begin
            w_code_nxt  = f_pick(r_pending);
            w_state_nxt = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (w_ack) begin
            if (w_rem != 8'd0) begin
              w_code_nxt = f_pick(w_rem);
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_code    <= 3'd0;
      r_pending <= 8'd0;
      r_dup_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_pending <= w_pending_nxt;
      r_dup_err <= w_dup_err_nxt;
    end
  end

  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_count = w_count + 4'(r_pending[i]);
    end
  end

  // valid is exactly "in PRESENT", so it is registered by construction.
  assign bus.valid      = (r_state == S_PRESENT);
  assign bus.code_out   = r_code;
  assign bus.pending    = r_pending;
  assign bus.pend_count = w_count;
  assign bus.dup_err    = r_dup_err;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_codificador_8a3_secuencial.sv
// ---------------------------------------------------------------------------
// tb_codificador_8a3_secuencial
//   Directed bench for the registered 8-to-3 priority encoder. dut_a uses
//   PRIORITY_HIGH=1, dut_b uses PRIORITY_HIGH=0. Inputs change 1 ns after
//   a rising edge; outputs are checked at that same point, after they have
//   settled from the edge.
// ---------------------------------------------------------------------------
module tb_codificador_8a3_secuencial;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  codificador_8a3_secuencial_if ifa ();
  codificador_8a3_secuencial_if ifb ();

  codificador_8a3_secuencial #(.PRIORITY_HIGH(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  codificador_8a3_secuencial #(.PRIORITY_HIGH(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic rd, input logic cl);
    ifa.req_in = r;
    ifa.ready  = rd;
    ifa.clear  = cl;
  endtask

  task automatic test_reset();
    drive(8'h00, 1'b0, 1'b0);
    ifb.req_in = 8'h00; ifb.ready = 1'b0; ifb.clear = 1'b0;
    rst_n = 1'b0;
    #12;
    tests++; if (ifa.valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", ifa.valid); end
    tests++; if (ifa.pending !== 8'h00) begin fails++; $display("FAIL rst_pending got %h exp 00", ifa.pending); end
    tests++; if (ifa.code_out !== 3'd0) begin fails++; $display("FAIL rst_code got %0d exp 0", ifa.code_out); end
    tests++; if (ifa.pend_count !== 4'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", ifa.pend_count); end
    tests++; if (ifa.dup_err !== 1'b0) begin fails++; $display("FAIL rst_dup got %b exp 0", ifa.dup_err); end
    tests++; if (ifa.state_dbg !== 1'b0) begin fails++; $display("FAIL rst_state got %b exp 0", ifa.state_dbg); end
    step();
    rst_n = 1'b1;
    step();
    // Bring the encoder into PRESENT with code 5 and ready low.
    drive(8'h20, 1'b0, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0); step();
    tests++; if (ifa.valid !== 1'b1 || ifa.code_out !== 3'd5) begin fails++; $display("FAIL rst_setup got v=%b c=%0d exp v=1 c=5", ifa.valid, ifa.code_out); end
    tests++; if (ifa.state_dbg !== 1'b1) begin fails++; $display("FAIL rst_setup_state got %b exp 1", ifa.state_dbg); end
    #3 rst_n = 1'b0;
    #1;
    tests++; if (ifa.valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b exp 0", ifa.valid); end
    tests++; if (ifa.pending !== 8'h00) begin fails++; $display("FAIL rst_mid_pending got %h exp 00", ifa.pending); end
    tests++; if (ifa.code_out !== 3'd0) begin fails++; $display("FAIL rst_mid_code got %0d exp 0", ifa.code_out); end
    step(); step();
    rst_n = 1'b1;
    drive(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (ifa.valid !== 1'b0 || ifa.pending !== 8'h00) begin fails++; $display("FAIL rst_after cyc=%0d got v=%b p=%h exp v=0 p=00", i, ifa.valid, ifa.pending); end
    end
  endtask

  task automatic test_single_sweep();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] v;
      v = 8'd1 << k;
      drive(v, 1'b1, 1'b0); step();
      tests++; if (ifa.pending !== v || ifa.pend_count !== 4'd1 || ifa.valid !== 1'b0) begin fails++; $display("FAIL sweep_latch k=%0d got p=%h n=%0d v=%b exp p=%h n=1 v=0", k, ifa.pending, ifa.pend_count, ifa.valid, v); end
      drive(8'h00, 1'b1, 1'b0); step();
      tests++; if (ifa.valid !== 1'b1 || ifa.code_out !== 3'(k) || ifa.pend_count !== 4'd1) begin fails++; $display("FAIL sweep_present k=%0d got v=%b c=%0d n=%0d exp v=1 c=%0d n=1", k, ifa.valid, ifa.code_out, ifa.pend_count, k); end
      step();
      tests++; if (ifa.valid !== 1'b0 || ifa.pend_count !== 4'd0) begin fails++; $display("FAIL sweep_done k=%0d got v=%b n=%0d exp v=0 n=0", k, ifa.valid, ifa.pend_count); end
    end
  endtask

  task automatic test_multi_hot();
    int exp_c [4] = '{7, 5, 2, 0};
    int exp_n [4] = '{4, 3, 2, 1};
    drive(8'hA5, 1'b1, 1'b0); step();
    drive(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (ifa.valid !== 1'b1 || ifa.code_out !== 3'(exp_c[i]) || ifa.pend_count !== 4'(exp_n[i])) begin fails++; $display("FAIL multi i=%0d got v=%b c=%0d n=%0d exp v=1 c=%0d n=%0d", i, ifa.valid, ifa.code_out, ifa.pend_count, exp_c[i], exp_n[i]); end
    end
    step();
    tests++; if (ifa.valid !== 1'b0 || ifa.pend_count !== 4'd0) begin fails++; $display("FAIL multi_end got v=%b n=%0d exp v=0 n=0", ifa.valid, ifa.pend_count); end
  endtask

  task automatic test_backpressure();
    drive(8'h01, 1'b0, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (ifa.valid !== 1'b1 || ifa.code_out !== 3'd0) begin fails++; $display("FAIL bp_hold i=%0d got v=%b c=%0d exp v=1 c=0", i, ifa.valid, ifa.code_out); end
    end
    drive(8'h80, 1'b0, 1'b0); step();
    tests++; if (ifa.pending !== 8'h81 || ifa.code_out !== 3'd0) begin fails++; $display("FAIL bp_nopreempt got p=%h c=%0d exp p=81 c=0", ifa.pending, ifa.code_out); end
    drive(8'h00, 1'b0, 1'b0); step();
    tests++; if (ifa.valid !== 1'b1 || ifa.code_out !== 3'd0) begin fails++; $display("FAIL bp_still0 got v=%b c=%0d exp v=1 c=0", ifa.valid, ifa.code_out); end
    drive(8'h00, 1'b1, 1'b0); step();
    tests++; if (ifa.valid !== 1'b1 || ifa.code_out !== 3'd7 || ifa.pending !== 8'h80) begin fails++; $display("FAIL bp_second got v=%b c=%0d p=%h exp v=1 c=7 p=80", ifa.valid, ifa.code_out, ifa.pending); end
    step();
    tests++; if (ifa.valid !== 1'b0 || ifa.pending !== 8'h00) begin fails++; $display("FAIL bp_end got v=%b p=%h exp v=0 p=00", ifa.valid, ifa.pending); end
  endtask

  task automatic test_collisions();
    // Case A: repeat request while bit 2 is pending and not acknowledged.
    drive(8'h04, 1'b0, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0); step();
    tests++; if (ifa.dup_err !== 1'b0 || ifa.code_out !== 3'd2) begin fails++; $display("FAIL colA_pre got d=%b c=%0d exp d=0 c=2", ifa.dup_err, ifa.code_out); end
    drive(8'h04, 1'b0, 1'b0); step();
    tests++; if (ifa.dup_err !== 1'b1) begin fails++; $display("FAIL colA_dup got %b exp 1", ifa.dup_err); end
    drive(8'h00, 1'b0, 1'b0); step();
    tests++; if (ifa.dup_err !== 1'b1) begin fails++; $display("FAIL colA_sticky got %b exp 1", ifa.dup_err); end
    drive(8'h00, 1'b0, 1'b1); step();
    tests++; if (ifa.dup_err !== 1'b0 || ifa.valid !== 1'b0 || ifa.pending !== 8'h00) begin fails++; $display("FAIL colA_clear got d=%b v=%b p=%h exp d=0 v=0 p=00", ifa.dup_err, ifa.valid, ifa.pending); end
    // Case B: same request during the acknowledge cycle of code 2.
    drive(8'h04, 1'b0, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0); step();
    drive(8'h04, 1'b1, 1'b0); step();
    tests++; if (ifa.pending !== 8'h04 || ifa.valid !== 1'b0 || ifa.dup_err !== 1'b0) begin fails++; $display("FAIL colB_ack got p=%h v=%b d=%b exp p=04 v=0 d=0", ifa.pending, ifa.valid, ifa.dup_err); end
    drive(8'h00, 1'b1, 1'b0); step();
    tests++; if (ifa.valid !== 1'b1 || ifa.code_out !== 3'd2 || ifa.dup_err !== 1'b0) begin fails++; $display("FAIL colB_again got v=%b c=%0d d=%b exp v=1 c=2 d=0", ifa.valid, ifa.code_out, ifa.dup_err); end
    step();
    tests++; if (ifa.valid !== 1'b0 || ifa.pending !== 8'h00) begin fails++; $display("FAIL colB_end got v=%b p=%h exp v=0 p=00", ifa.valid, ifa.pending); end
  endtask

  task automatic test_clear();
    drive(8'h03, 1'b0, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0); step();
    drive(8'h01, 1'b0, 1'b0); step();
    tests++; if (ifa.code_out !== 3'd1 || ifa.dup_err !== 1'b1) begin fails++; $display("FAIL clr_setup got c=%0d d=%b exp c=1 d=1", ifa.code_out, ifa.dup_err); end
    drive(8'hFF, 1'b1, 1'b1); step();
    tests++; if (ifa.pending !== 8'h00 || ifa.valid !== 1'b0 || ifa.dup_err !== 1'b0 || ifa.pend_count !== 4'd0) begin fails++; $display("FAIL clr_flush got p=%h v=%b d=%b n=%0d exp p=00 v=0 d=0 n=0", ifa.pending, ifa.valid, ifa.dup_err, ifa.pend_count); end
    tests++; if (ifa.code_out !== 3'd1) begin fails++; $display("FAIL clr_code_keep got %0d exp 1", ifa.code_out); end
    drive(8'h00, 1'b0, 1'b0); step();
    tests++; if (ifa.valid !== 1'b0 || ifa.pending !== 8'h00) begin fails++; $display("FAIL clr_after got v=%b p=%h exp v=0 p=00", ifa.valid, ifa.pending); end
  endtask

  task automatic test_priority_low();
    ifb.req_in = 8'h81; ifb.ready = 1'b1; ifb.clear = 1'b0; step();
    tests++; if (ifb.pend_count !== 4'd2) begin fails++; $display("FAIL lo_count got %0d exp 2", ifb.pend_count); end
    ifb.req_in = 8'h00; step();
    tests++; if (ifb.valid !== 1'b1 || ifb.code_out !== 3'd0) begin fails++; $display("FAIL lo_first got v=%b c=%0d exp v=1 c=0", ifb.valid, ifb.code_out); end
    step();
    tests++; if (ifb.valid !== 1'b1 || ifb.code_out !== 3'd7) begin fails++; $display("FAIL lo_second got v=%b c=%0d exp v=1 c=7", ifb.valid, ifb.code_out); end
    step();
    tests++; if (ifb.valid !== 1'b0 || ifb.pending !== 8'h00) begin fails++; $display("FAIL lo_end got v=%b p=%h exp v=0 p=00", ifb.valid, ifb.pending); end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_multi_hot();
    test_backpressure();
    test_collisions();
    test_clear();
    test_priority_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
